// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-compatible character-LCD controller:
//   - FSM state encoding
//   - HD44780 command byte constants
//   - power-on init ROM entry type and the hard-wired init table
//   - small helpers used to size and load the shared down-counter
// Used by lcd_char_ctrl (top) and lcd_cmd_fifo.
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_EN_LO,
        ST_WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;  // home with the don't-care bit set
    localparam logic [7:0] CMD_FUNC8    = 8'h38;
    localparam logic [7:0] CMD_FUNC4    = 8'h28;
    localparam logic [7:0] CMD_DISP_OFF = 8'h08;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_WAKE8    = 8'h30;  // "function set 8-bit" wake-up byte
    localparam logic [7:0] CMD_WAKE4    = 8'h20;  // high nibble 0x2 switches the panel to 4-bit

    // One init step. 'single' sends only the high nibble on a 4-bit bus;
    // 'long_wait' forces the clear/home wait after the strobe.
    typedef struct packed {
        logic [7:0] data;
        logic       single;
        logic       long_wait;
    } init_entry_t;

    localparam logic [3:0] INIT_LEN8 = 4'd8;
    localparam logic [3:0] INIT_LEN4 = 4'd9;

    function automatic int clamp1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic init_entry_t init_entry(input logic four_bit, input logic [3:0] idx);
        init_entry_t e;
        e.data      = 8'h00;
        e.single    = 1'b0;
        e.long_wait = 1'b0;
        if (four_bit) begin
            case (idx)
                4'd0, 4'd1, 4'd2: begin e.data = CMD_WAKE8; e.single = 1'b1; e.long_wait = 1'b1; end
                4'd3:             begin e.data = CMD_WAKE4; e.single = 1'b1; e.long_wait = 1'b1; end
                4'd4:             e.data = CMD_FUNC4;
                4'd5:             e.data = CMD_DISP_OFF;
                4'd6:             e.data = CMD_CLEAR;
                4'd7:             e.data = CMD_ENTRY;
                4'd8:             e.data = CMD_DISP_ON;
                default:          e.data = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0, 4'd1, 4'd2: begin e.data = CMD_WAKE8; e.long_wait = 1'b1; end
                4'd3:             e.data = CMD_FUNC8;
                4'd4:             e.data = CMD_DISP_OFF;
                4'd5:             e.data = CMD_CLEAR;
                4'd6:             e.data = CMD_ENTRY;
                4'd7:             e.data = CMD_DISP_ON;
                default:          e.data = 8'h00;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// -----------------------------------------------------------------------------
// lcd_cmd_fifo
// Synchronous FIFO holding {rs, data} entries for the LCD controller.
// Read data is registered: rd_data holds the popped entry from the clock edge
// after rd_en until the next pop.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (pointers and count only)
//   wr_en    in   push request; ignored while full
//   wr_data  in   entry to push
//   full     out  no free entry
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  last popped entry
//   empty    out  no stored entry
// -----------------------------------------------------------------------------
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO never takes a write, even when a pop happens on the same edge.
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop)  rd_data     <= mem[rd_ptr];
    end

endmodule

// File: rtl/lcd_char_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_char_ctrl
// HD44780-compatible character-LCD write controller with a command/data FIFO,
// 8-bit or 4-bit bus, and all strobe/execution timing generated in hardware.
// Optional feature macro: LCD_INIT_EN -- when defined, a hard-wired power-on
// init sequence runs after reset before queued writes are sent.
// Ports:
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   wr_valid       in   write request
//   wr_ready       out  FIFO not full; write accepted on wr_valid && wr_ready
//   wr_rs          in   0 = command, 1 = character data
//   wr_data[7:0]   in   byte to send
//   busy           out  FIFO non-empty, FSM not idle, or init running
//   lcd_rs         out  LCD register select
//   lcd_rw         out  LCD read/write, always 0 (write-only)
//   lcd_en         out  LCD enable strobe
//   lcd_data[7:0]  out  LCD data; in 4-bit mode nibble on [7:4], [3:0] = 0
// -----------------------------------------------------------------------------
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int TAS_CYC     = 4,
    parameter int EN_CYC      = 12,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 80000,
    parameter int POWERUP_CYC = 750000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    // Any BUS_WIDTH other than 4 builds the 8-bit bus.
    localparam logic FOUR_BIT = (BUS_WIDTH == 4);

    localparam int MAX_CYC = max2(max2(clamp1(TAS_CYC), clamp1(EN_CYC)),
                                  max2(max2(clamp1(EXEC_CYC), clamp1(CLEAR_CYC)),
                                       clamp1(POWERUP_CYC)));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // A timed state lasts N cycles when entered with the counter at N-1.
    // Setup after a FIFO pop gets one extra count: the first cycle is spent
    // waiting for the registered FIFO read before lcd_rs/lcd_data are driven.
    localparam logic [CNT_W-1:0] TAS_POP_LD = CNT_W'(clamp1(TAS_CYC));
    localparam logic [CNT_W-1:0] TAS_LD     = CNT_W'(clamp1(TAS_CYC) - 1);
    localparam logic [CNT_W-1:0] EN_LD      = CNT_W'(clamp1(EN_CYC) - 1);
    localparam logic [CNT_W-1:0] EXEC_LD    = CNT_W'(clamp1(EXEC_CYC) - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD   = CNT_W'(clamp1(CLEAR_CYC) - 1);
    localparam logic [CNT_W-1:0] PWR_LD     = CNT_W'(clamp1(POWERUP_CYC) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    lcd_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_rs;
    logic [7:0]       cur_byte;
    logic             long_wait;
    logic             lo_pending;   // 4-bit: high nibble sent, low nibble still to go
    logic             load;         // FIFO read data becomes valid this cycle
    logic             long_now;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [8:0]       fifo_head;

`ifdef LCD_INIT_EN
    localparam logic [3:0] ROM_LEN = FOUR_BIT ? INIT_LEN4 : INIT_LEN8;
    logic [3:0]  rom_idx;
    init_entry_t rom_e;
    assign rom_e = init_entry(FOUR_BIT, rom_idx);
`endif

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .wr_en   (wr_valid),
        .wr_data ({wr_rs, wr_data}),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign busy     = !fifo_empty || (state != ST_IDLE);
    assign lcd_rw   = 1'b0;

    // Clear and home need the long execution wait; init wake-up bytes force it too.
    assign long_now = long_wait ||
                      (!cur_rs && (cur_byte == CMD_CLEAR || cur_byte == CMD_HOME ||
                                   cur_byte == CMD_HOME_ALT));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
`ifdef LCD_INIT_EN
            state   <= ST_INIT;
            cnt     <= PWR_LD;
            rom_idx <= '0;
`else
            state   <= ST_IDLE;
            cnt     <= '0;
`endif
            cur_rs     <= 1'b0;
            cur_byte   <= 8'h00;
            long_wait  <= 1'b0;
            lo_pending <= 1'b0;
            load       <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_data   <= 8'h00;
        end else begin
            load <= 1'b0;
            case (state)
                ST_INIT: begin
`ifdef LCD_INIT_EN
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (rom_idx == ROM_LEN) begin
                        state <= ST_IDLE;
                    end else begin
                        cur_rs     <= 1'b0;
                        cur_byte   <= rom_e.data;
                        long_wait  <= rom_e.long_wait;
                        lo_pending <= FOUR_BIT && !rom_e.single;
                        lcd_rs     <= 1'b0;
                        lcd_data   <= FOUR_BIT ? {rom_e.data[7:4], 4'h0} : rom_e.data;
                        rom_idx    <= rom_idx + 1'b1;
                        cnt        <= TAS_LD;
                        state      <= ST_SETUP;
                    end
`else
                    state <= ST_IDLE;
`endif
                end

                ST_IDLE: begin
                    if (!fifo_empty) begin
                        load  <= 1'b1;
                        cnt   <= TAS_POP_LD;
                        state <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (load) begin
                        cur_rs     <= fifo_head[8];
                        cur_byte   <= fifo_head[7:0];
                        long_wait  <= 1'b0;
                        lo_pending <= FOUR_BIT;
                        lcd_rs     <= fifo_head[8];
                        lcd_data   <= FOUR_BIT ? {fifo_head[7:4], 4'h0} : fifo_head[7:0];
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        lcd_en <= 1'b1;
                        cnt    <= EN_LD;
                        state  <= ST_EN_HI;
                    end
                end

                ST_EN_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        lcd_en <= 1'b0;
                        cnt    <= EN_LD;
                        state  <= ST_EN_LO;
                    end
                end

                ST_EN_LO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (lo_pending) begin
                        lo_pending <= 1'b0;
                        lcd_data   <= {cur_byte[3:0], 4'h0};
                        cnt        <= TAS_LD;
                        state      <= ST_SETUP;
                    end else begin
                        cnt   <= long_now ? CLEAR_LD : EXEC_LD;
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
`ifdef LCD_INIT_EN
                        state <= (rom_idx == ROM_LEN) ? ST_IDLE : ST_INIT;
`else
                        state <= ST_IDLE;
`endif
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
